// File: rtl/col_scheduler_if.sv
// AXI-Stream style beat channel from the column scheduler
// to the process engine; tuser carries the one-hot source column.
interface col_scheduler_if #(
    parameter int DATA_WIDTH   = 128,
    parameter int COL_MAX_SIZE = 4
);
    logic [DATA_WIDTH-1:0]   m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic [COL_MAX_SIZE-1:0] m_tuser;
    logic                    m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tuser,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tuser,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/col_scheduler.sv
// Round-robin drain of column FWFT FIFOs into one registered beat stream.
// Optional watchdog: define COL_SCHED_TIMEOUT_EN.
module col_scheduler #(
    parameter int TCQ          = 1,
    parameter int DATA_WIDTH   = 128,
    parameter int COL_MAX_SIZE = 4,
    parameter int BURST_LEN    = 4
) (
    input  logic                             user_clk,
    input  logic                             user_rst,
    input  logic                             partition_done,
    input  logic [15:0]                      data_rows_i,
    input  logic [COL_MAX_SIZE-1:0]          data_fifo_empty,
    input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] data_fifo_dout,
    output logic [COL_MAX_SIZE-1:0]          data_fifo_rd_en,
    col_scheduler_if.master                  m_axis,
    output logic                             process_done,
    output logic                             sched_error
);

    localparam int PW = (COL_MAX_SIZE > 1) ? $clog2(COL_MAX_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   rows_q;
    logic [PW-1:0] ptr_q, gidx_q, arb_idx, ptr_d;
    logic [7:0]    burst_q;
    logic          arb_hit, pop, accept, timeout;

    if (TCQ < 0 || BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_param
    end

    // Search starts one past the last granted column.
    always_comb begin
        logic [PW:0] k;
        arb_hit = 1'b0;
        arb_idx = '0;
        k       = '0;
        for (int i = 0; i < COL_MAX_SIZE; i++) begin
            k = {1'b0, ptr_q} + (PW+1)'(i);
            if (k >= (PW+1)'(COL_MAX_SIZE))
                k = k - (PW+1)'(COL_MAX_SIZE);
            if (!arb_hit && !data_fifo_empty[k[PW-1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = k[PW-1:0];
            end
        end
    end

    assign ptr_d = (arb_idx == PW'(COL_MAX_SIZE-1)) ? '0 : arb_idx + 1'b1;

    always_comb begin
        data_fifo_rd_en = '0;
        if (state_q == XFER && !data_fifo_empty[gidx_q] && rows_q != '0 &&
            (!m_axis.m_tvalid || m_axis.m_tready))
            data_fifo_rd_en[gidx_q] = 1'b1;
    end

    assign pop    = |data_fifo_rd_en;
    assign accept = m_axis.m_tvalid & m_axis.m_tready;

`ifdef COL_SCHED_TIMEOUT_EN
    logic [15:0] idle_q;

    always_ff @(posedge user_clk or negedge user_rst) begin
        if (!user_rst) begin
            idle_q      <= '0;
            sched_error <= 1'b0;
        end else begin
            if ((state_q != ARB && state_q != XFER) || pop || accept)
                idle_q <= '0;
            else if (idle_q != 16'hFFFF)
                idle_q <= idle_q + 16'd1;
            if (timeout)
                sched_error <= 1'b1;
        end
    end

    assign timeout = (state_q == ARB || state_q == XFER) && idle_q == 16'hFFFF;
`else
    assign timeout     = 1'b0;
    assign sched_error = 1'b0;
`endif

    // The last beat holds XFER until it is accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (partition_done)
                state_d = (data_rows_i != '0) ? ARB : DONE;
            ARB:  if (arb_hit) state_d = XFER;
            XFER: begin
                if (accept && m_axis.m_tlast)
                    state_d = DONE;
                else if (rows_q == '0 || (pop && rows_q == 16'd1))
                    state_d = XFER;
                else if (pop && burst_q == 8'(BURST_LEN-1))
                    state_d = ARB;
                else if (!pop && data_fifo_empty[gidx_q])
                    state_d = ARB;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout)
            state_d = DONE;
    end

    always_ff @(posedge user_clk or negedge user_rst) begin
        if (!user_rst) begin
            state_q         <= IDLE;
            rows_q          <= '0;
            ptr_q           <= '0;
            gidx_q          <= '0;
            burst_q         <= '0;
            m_axis.m_tdata  <= '0;
            m_axis.m_tvalid <= 1'b0;
            m_axis.m_tuser  <= '0;
            m_axis.m_tlast  <= 1'b0;
            process_done    <= 1'b0;
        end else begin
            state_q      <= state_d;
            process_done <= (state_q == DONE);

            if (state_q == IDLE && partition_done)
                rows_q <= data_rows_i;
            else if (pop && rows_q != '0)
                rows_q <= rows_q - 16'd1;

            if (state_q == ARB && arb_hit) begin
                gidx_q  <= arb_idx;
                ptr_q   <= ptr_d;
                burst_q <= '0;
            end else if (pop) begin
                burst_q <= burst_q + 8'd1;
            end

            if (pop) begin
                m_axis.m_tdata  <= data_fifo_dout[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
                m_axis.m_tuser  <= data_fifo_rd_en;
                m_axis.m_tlast  <= (rows_q == 16'd1);
                m_axis.m_tvalid <= 1'b1;
            end else if (accept || timeout) begin
                m_axis.m_tvalid <= 1'b0;
            end
        end
    end

endmodule
